// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: RV32I load/store funct3
//   encodings, the sequencing FSM state type and an access-size helper.
// -----------------------------------------------------------------------------
package lsu_pkg;

  // RV32I load/store width encodings (funct3). BU/HU exist for loads only.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } lsu_state_e;

  // Access size in bytes. funct3[1:0] carries the width; funct3[2] only
  // selects zero- vs sign-extension. Unused encodings report 4, which is
  // harmless because they are rejected as illegal before use.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Request/response channel between the pipeline MEM stage (master) and the
//   load/store unit (slave).
//   req_valid/req_ready     : accept handshake, accept when both are high
//   req_is_load/req_is_store: direction (exactly one must be set)
//   req_funct3              : RV32I width/extension code
//   req_addr/req_wdata      : effective byte address and store data (rs2)
//   resp_valid/resp_err     : one-cycle completion pulse and its error flag
//   load_data               : extended load result
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_err;
  logic [XLEN-1:0] load_data;

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, load_data
  );

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, load_data
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational load-data extension. The data memory returns the accessed
//   byte/half zero-extended in the low bits; this applies the RV32I rule.
//   funct3 : load width/extension code
//   rdata  : raw memory read data
//   data   : extended result (B/H sign-extend, BU/HU zero-extend, W as-is)
// -----------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  always_comb begin
    // NOTE: default assignment first, so every path drives data and no latch is inferred.
    data = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, rdata[7:0]};
      F3_H:    data = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory interface. Accepts one load/store from
//   the MEM stage, screens it (illegal / misaligned / out of range), drives a
//   single-cycle memory strobe and returns a one-cycle response.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : request/response channel, see load_store_unit_if
//   mem_addr     : byte address to memory, held until the next accept
//   mem_read     : read strobe, one cycle per good load
//   mem_write    : write strobe, one cycle per good store
//   mem_half     : access is a halfword
//   mem_byte     : access is a byte
//   mem_wdata    : store data to memory, held until the next accept
//   mem_rdata    : memory read data, valid the cycle after mem_read
// Latency from accept edge to resp_valid: load 3, store 2, error 1 cycle.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int XLEN      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_half,
  output logic                mem_byte,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

  lsu_state_e      state;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic [XLEN-1:0] ext_data;

  // ---------------------------------------------------------------------------
  // Request screening, evaluated on the incoming request while IDLE.
  // ---------------------------------------------------------------------------
  logic          req_byte;
  logic          req_half;
  logic          req_word;
  logic          req_illegal;
  logic          req_misaligned;
  logic          req_out_of_range;
  logic          req_bad;
  logic [XLEN:0] req_last_byte;

  assign req_byte = (bus.req_funct3[1:0] == 2'b00);
  assign req_half = (bus.req_funct3[1:0] == 2'b01);
  assign req_word = (bus.req_funct3[1:0] == 2'b10);

  assign req_illegal =
      (bus.req_is_load == bus.req_is_store)
    | (bus.req_is_store & ~(bus.req_funct3 inside {F3_B, F3_H, F3_W}))
    | (bus.req_is_load  &  (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}));

  assign req_misaligned = (req_half & bus.req_addr[0])
                        | (req_word & (bus.req_addr[1:0] != 2'b00));

  // Last byte touched, one bit wider than the address so a request near the
  // top of the address space cannot wrap back into range.
  assign req_last_byte = {1'b0, bus.req_addr}
                       + {{(XLEN-2){1'b0}}, size_bytes(bus.req_funct3)}
                       - {{XLEN{1'b0}}, 1'b1};

  assign req_out_of_range = (req_last_byte >= MEM_LIMIT);
  assign req_bad          = req_illegal | req_misaligned | req_out_of_range;

  // Ready is the only combinational output.
  assign bus.req_ready = (state == ST_IDLE);

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (funct3_q),
    .rdata  (mem_rdata),
    .data   (ext_data)
  );

  // ---------------------------------------------------------------------------
  // Sequencing FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      funct3_q       <= 3'b000;
      is_load_q      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.load_data  <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_half       <= 1'b0;
      mem_byte       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            funct3_q  <= bus.req_funct3;
            is_load_q <= bus.req_is_load;
            mem_addr  <= bus.req_addr;
            mem_wdata <= bus.req_wdata;
            if (req_bad) begin
              // Rejected requests never touch memory.
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              mem_read  <= bus.req_is_load;
              mem_write <= bus.req_is_store;
              mem_half  <= req_half;
              mem_byte  <= req_byte;
            end
          end
        end

        ST_ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_half  <= 1'b0;
          mem_byte  <= 1'b0;
          if (is_load_q) begin
            state <= ST_CAPTURE;
          end else begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          // Memory data registered at the end of ACCESS is valid now.
          bus.load_data  <= ext_data;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          state          <= ST_RESP;
        end

        ST_RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          state          <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench: byte-array data memory with registered, zero-extending
//   reads; a reference model computing each request's outcome from the RV32I
//   rules with plain integer arithmetic; directed and randomized requests.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 256;
  localparam int XLEN      = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_init;

  load_store_unit_if #(.XLEN(XLEN)) bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_half  (mem_half),
    .mem_byte  (mem_byte),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Data memory: registered read, zero-extends sub-word data.
  // ---------------------------------------------------------------------------
  logic [7:0] tb_mem  [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) tb_mem[i] <= ref_mem[i];
      mem_rdata <= '0;
    end else begin
      if (mem_write) begin
        tb_mem[mem_addr[7:0]] <= mem_wdata[7:0];
        if (!mem_byte) tb_mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
        if (!mem_byte && !mem_half) begin
          tb_mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
          tb_mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
        end
      end
      if (mem_read) begin
        if (mem_byte)      mem_rdata <= {24'h0, tb_mem[mem_addr[7:0]]};
        else if (mem_half) mem_rdata <= {16'h0, tb_mem[mem_addr[7:0] + 8'd1], tb_mem[mem_addr[7:0]]};
        else               mem_rdata <= {tb_mem[mem_addr[7:0] + 8'd3], tb_mem[mem_addr[7:0] + 8'd2],
                                         tb_mem[mem_addr[7:0] + 8'd1], tb_mem[mem_addr[7:0]]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] exp_ld = 32'h0;

  function automatic longint rb(input logic [31:0] x);
    return longint'(ref_mem[x[7:0]]);
  endfunction

  task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output logic err);
    int     sz;
    longint v;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (ld == st)
       || (st && f3 > 3'd2)
       || (ld && (f3 == 3'd3 || f3 >= 3'd6))
       || (longint'(a) % sz != 0)
       || (longint'(a) + sz > MEM_BYTES);
    if (err) return;
    if (st) begin
      for (int i = 0; i < sz; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = sz - 1; i >= 0; i--) v = v * 256 + rb(a + i);
      if ((f3 == F3_B || f3 == F3_H) && v >= (longint'(1) << (8*sz - 1)))
        v -= (longint'(1) << (8*sz));
      exp_ld = 32'(v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One request, fully checked: latency, error, data, strobes, pulse width.
  // ---------------------------------------------------------------------------
  task automatic issue(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    int          waitc, lat, rdc, wrc, bothc, exp_lat;
    logic        sh, sb, exp_err;
    logic [31:0] sa, sw;
    sh = 0; sb = 0; sa = 0; sw = 0;
    rdc = 0; wrc = 0; bothc = 0;
    model(ld, st, f3, a, wd, exp_err);
    @(negedge clk);
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      check({tag, " ready timeout"}, 32'(bus.req_ready), 1);
      got = bus.load_data;
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_is_load  = ld;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Scramble the request so only latched values can be used.
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
      end
      if (mem_read)  rdc++;
      if (mem_write) wrc++;
      if (mem_read && mem_write) bothc++;
      if (mem_read || mem_write) begin
        sh = mem_half; sb = mem_byte; sa = mem_addr; sw = mem_wdata;
      end
    end while (!bus.resp_valid && lat < 10);
    exp_lat = exp_err ? 1 : (ld ? 3 : 2);
    check({tag, " latency"},   lat, exp_lat);
    check({tag, " resp_err"},  32'(bus.resp_err), 32'(exp_err));
    check({tag, " load_data"}, bus.load_data, exp_ld);
    check({tag, " read strobes"},  rdc, (ld && !exp_err) ? 1 : 0);
    check({tag, " write strobes"}, wrc, (st && !exp_err) ? 1 : 0);
    check({tag, " read+write"}, bothc, 0);
    if (!exp_err) begin
      check({tag, " mem_byte"}, 32'(sb), 32'(f3[1:0] == 2'b00));
      check({tag, " mem_half"}, 32'(sh), 32'(f3[1:0] == 2'b01));
      check({tag, " mem_addr"}, sa, a);
      if (st) check({tag, " mem_wdata"}, sw, wd);
    end
    got = bus.load_data;
    @(negedge clk);
    check({tag, " resp pulse"}, 32'(bus.resp_valid), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready), 1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 0);
    check({tag, " resp_err"},   32'(bus.resp_err), 0);
    check({tag, " load_data"},  bus.load_data, 0);
    check({tag, " mem_read"},   32'(mem_read), 0);
    check({tag, " mem_write"},  32'(mem_write), 0);
    check({tag, " mem_half"},   32'(mem_half), 0);
    check({tag, " mem_byte"},   32'(mem_byte), 0);
    check({tag, " mem_addr"},   mem_addr, 0);
    check({tag, " mem_wdata"},  mem_wdata, 0);
  endtask

  // Three loads with req_valid held high: accepts 4 cycles apart, in order.
  task automatic back_to_back();
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    logic [31:0] exp_q [$];
    int          n_acc, n_resp, last_acc;
    logic        e;
    addrs = '{32'd0, 32'd8, 32'd1};
    f3s   = '{F3_W, F3_HU, F3_B};
    n_acc = 0; n_resp = 0; last_acc = 0;
    for (int cyc = 0; cyc < 40 && n_resp < 3; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) check("b2b spurious resp", 32'(bus.resp_valid), 0);
        else check("b2b load_data", bus.load_data, exp_q.pop_front());
        n_resp++;
      end
      if (n_acc < 3 && bus.req_ready) begin
        bus.req_valid    = 1'b1;
        bus.req_is_load  = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = f3s[n_acc];
        bus.req_addr     = addrs[n_acc];
        bus.req_wdata    = $urandom;
        model(1'b1, 1'b0, f3s[n_acc], addrs[n_acc], 32'h0, e);
        exp_q.push_back(exp_ld);
        if (n_acc > 0) check("b2b accept gap", cyc - last_acc, 4);
        last_acc = cyc;
        n_acc++;
      end else if (n_acc == 3 && !bus.req_ready) begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b responses", n_resp, 3);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] got;
    int          r, sz, resp_seen;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'hFF; ref_mem[1] = 8'h54; ref_mem[2] = 8'h00;
    mem_init = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_state("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n    = 1'b1;

    // Preloaded-memory loads.
    issue("lb 0",  1, 0, F3_B,  0, 0, got); check("lb 0 value",  got, 32'hFFFFFFFF);
    issue("lbu 0", 1, 0, F3_BU, 0, 0, got); check("lbu 0 value", got, 32'h000000FF);
    issue("lh 0",  1, 0, F3_H,  0, 0, got); check("lh 0 value",  got, 32'h000054FF);

    // Stores then loads.
    issue("sw 8",   0, 1, F3_W,  8, 32'h80001234, got);
    issue("lw 8",   1, 0, F3_W,  8, 0, got); check("lw 8 value",   got, 32'h80001234);
    issue("lh 10",  1, 0, F3_H, 10, 0, got); check("lh 10 value",  got, 32'hFFFF8000);
    issue("lhu 10", 1, 0, F3_HU,10, 0, got); check("lhu 10 value", got, 32'h00008000);
    issue("sb 9",   0, 1, F3_B,  9, 32'h000000AB, got);
    issue("lw 8b",  1, 0, F3_W,  8, 0, got); check("lw 8 after sb", got, 32'h8000AB34);

    // Error cases: load_data must stay at 0x8000AB34.
    issue("lw 6 misaligned",  1, 0, F3_W,    6, 0, got);
    issue("sh 3 misaligned",  0, 1, F3_H,    3, 32'h1111, got);
    issue("lw 254 range",     1, 0, F3_W,  254, 0, got);
    issue("sbu illegal",      0, 1, F3_BU,   0, 32'h22, got);
    issue("ld+st illegal",    1, 1, F3_W,    0, 32'h33, got);
    issue("lb 256 range",     1, 0, F3_B,  256, 0, got);
    issue("lw ffffffff wrap", 1, 0, F3_W, 32'hFFFF_FFFC, 0, got);
    check("load_data after errors", got, 32'h8000AB34);

    // In-range boundary accesses.
    issue("lb 255",  1, 0, F3_B,  255, 0, got);
    issue("lhu 254", 1, 0, F3_HU, 254, 0, got);
    issue("sw 252",  0, 1, F3_W,  252, 32'hCAFEF00D, got);
    issue("lw 252",  1, 0, F3_W,  252, 0, got); check("lw 252 value", got, 32'hCAFEF00D);

    back_to_back();

    // Reset asserted during CAPTURE of a load.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_is_store = 1'b0;
    bus.req_funct3 = F3_W; bus.req_addr = 32'd8;
    @(posedge clk);              // accept, now ACCESS
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);              // now CAPTURE
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid-op reset");
    exp_ld = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
    end
    check("no resp after reset", resp_seen, 0);
    issue("lw 8 after reset", 1, 0, F3_W, 8, 0, got);

    // Randomized requests against the model.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      ld = (r < 5);
      st = (r >= 5 && r < 9);
      if (r == 9) begin ld = 1'($urandom); st = ld; end
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B; 1: f3 = F3_H; 2: f3 = F3_W; 3: f3 = F3_BU; default: f3 = F3_HU;
        endcase
      end
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      case ($urandom_range(0, 5))
        0:       a = $urandom_range(248, 259);
        1:       a = $urandom;
        2:       a = $urandom_range(0, 63);
        default: a = $urandom_range(0, 63) & ~(32'(sz) - 1);
      endcase
      wd = $urandom;
      issue($sformatf("rand %0d", n), ld, st, f3, a, wd, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
